// File: rtl/cu_pkg.sv
// Shared types and encodings for the multi-cycle control unit and its decoder.
package cu_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CLS_ADDI,
        CLS_ADD,
        CLS_SUB,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_BNE,
        CLS_LUI,
        CLS_ILLEGAL
    } instr_class_t;

    localparam logic [6:0] OP_IMM = 7'd19;
    localparam logic [6:0] OP     = 7'd51;
    localparam logic [6:0] LOAD   = 7'd3;
    localparam logic [6:0] STORE  = 7'd35;
    localparam logic [6:0] BRANCH = 7'd99;
    localparam logic [6:0] LUI    = 7'd55;

    localparam logic [2:0] IMM_I    = 3'b000;
    localparam logic [2:0] IMM_S    = 3'b001;
    localparam logic [2:0] IMM_B    = 3'b010;
    localparam logic [2:0] IMM_U    = 3'b011;
    localparam logic [2:0] IMM_NONE = 3'b111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_NONE = 3'b111;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_IMM = 2'b10;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_IMEM    = 2'b10;
    localparam logic [1:0] TRAP_DMEM    = 2'b11;

    function automatic logic is_mem_access(input instr_class_t cls);
        return (cls == CLS_LW) || (cls == CLS_SW);
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational classifier: opcode/funct3/sub-flag fields of the IR to an
// instruction class, with anything unsupported flagged illegal.
import cu_pkg::*;

module instr_decoder (
    input  logic [6:0]   opcode_i,
    input  logic [2:0]   funct3_i,
    input  logic         sub_i,
    output instr_class_t cls_o,
    output logic         illegal_o
);

    always_comb begin
        cls_o = CLS_ILLEGAL;
        case (opcode_i)
            OP_IMM: if (funct3_i == 3'b000) cls_o = CLS_ADDI;
            OP:     if (funct3_i == 3'b000) cls_o = sub_i ? CLS_SUB : CLS_ADD;
            LOAD:   if (funct3_i == 3'b010) cls_o = CLS_LW;
            STORE:  if (funct3_i == 3'b010) cls_o = CLS_SW;
            BRANCH: begin
                if (funct3_i == 3'b000)      cls_o = CLS_BEQ;
                else if (funct3_i == 3'b001) cls_o = CLS_BNE;
            end
            LUI:    cls_o = CLS_LUI;
            default: cls_o = CLS_ILLEGAL;
        endcase
    end

    assign illegal_o = (cls_o == CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_controlunit.sv
// Multi-cycle control FSM: fetch into IR, decode, execute, optional memory
// access and writeback, with bounded memory waits and a sticky trap state.
import cu_pkg::*;

module multicycle_controlunit #(
    parameter int WIDTH       = 32,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] instr,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             EQ,
    output logic             IRWrite,
    output logic             ImemRead,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             PCWrite,
    output logic             PCsrc,
    output logic             RegWrite,
    output logic             ALUsrc,
    output logic [2:0]       ImmSrc,
    output logic [2:0]       ALUctrl,
    output logic [1:0]       ResultSrc,
    output logic             trap,
    output logic [1:0]       trap_code,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state_o
);

    localparam int              WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   ir_q, ir_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]   retired_q;
    logic [1:0]         trap_code_q, trap_code_d;
    logic               retire;

    instr_class_t       cls;
    logic               illegal;
    logic               ir_unused;

    instr_decoder u_decoder (
        .opcode_i  (ir_q[6:0]),
        .funct3_i  (ir_q[14:12]),
        .sub_i     (ir_q[30]),
        .cls_o     (cls),
        .illegal_o (illegal)
    );

    // Source register fields and upper bits are consumed by the datapath, not here.
    assign ir_unused = ^{ir_q[WIDTH-1:31], ir_q[29:15]};

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        wait_cnt_d  = wait_cnt_q;
        trap_code_d = trap_code_q;
        retire      = 1'b0;
        IRWrite     = 1'b0;
        ImemRead    = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        PCWrite     = 1'b0;
        PCsrc       = 1'b0;
        RegWrite    = 1'b0;
        ALUsrc      = 1'b1;
        ImmSrc      = IMM_NONE;
        ALUctrl     = ALU_NONE;
        ResultSrc   = RES_ALU;

        case (state_q)
            FETCH: begin
                ImemRead = 1'b1;
                if (imem_ready) begin
                    IRWrite = 1'b1;
                    ir_d    = instr;
                    state_d = DECODE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d     = TRAP;
                    trap_code_d = TRAP_IMEM;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            DECODE: begin
                if (illegal) begin
                    state_d     = TRAP;
                    trap_code_d = TRAP_ILLEGAL;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = is_mem_access(cls) ? MEM : WB;
                case (cls)
                    CLS_ADDI, CLS_LW: begin
                        ImmSrc  = IMM_I;
                        ALUctrl = ALU_ADD;
                    end
                    CLS_SW: begin
                        ImmSrc  = IMM_S;
                        ALUctrl = ALU_ADD;
                    end
                    CLS_ADD: begin
                        ALUsrc  = 1'b0;
                        ALUctrl = ALU_ADD;
                    end
                    CLS_SUB: begin
                        ALUsrc  = 1'b0;
                        ALUctrl = ALU_SUB;
                    end
                    CLS_BEQ, CLS_BNE: begin
                        ALUsrc  = 1'b0;
                        ALUctrl = ALU_SUB;
                        ImmSrc  = IMM_B;
                        PCWrite = 1'b1;
                        PCsrc   = (cls == CLS_BEQ) ? EQ : !EQ;
                        retire  = 1'b1;
                        state_d = FETCH;
                    end
                    CLS_LUI: ImmSrc = IMM_U;
                    default: begin
                        state_d     = TRAP;
                        trap_code_d = TRAP_ILLEGAL;
                    end
                endcase
            end
            MEM: begin
                MemRead  = (cls == CLS_LW);
                MemWrite = (cls == CLS_SW);
                if (dmem_ready) begin
                    if (cls == CLS_SW) begin
                        PCWrite = 1'b1;
                        retire  = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d     = TRAP;
                    trap_code_d = TRAP_DMEM;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            WB: begin
                RegWrite = (ir_q[11:7] != 5'd0);
                case (cls)
                    CLS_LW:  ResultSrc = RES_MEM;
                    CLS_LUI: ResultSrc = RES_IMM;
                    default: ResultSrc = RES_ALU;
                endcase
                PCWrite = 1'b1;
                retire  = 1'b1;
                state_d = FETCH;
            end
            TRAP: state_d = TRAP;
            default: state_d = FETCH;
        endcase

        // Each wait phase starts its timeout budget from zero.
        if (state_d != state_q) wait_cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= FETCH;
            ir_q        <= '0;
            wait_cnt_q  <= '0;
            retired_q   <= '0;
            trap_code_q <= TRAP_NONE;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            wait_cnt_q  <= wait_cnt_d;
            trap_code_q <= trap_code_d;
            if (retire) retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign trap      = (state_q == TRAP);
    assign trap_code = trap_code_q;
    assign retired   = retired_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_multicycle_controlunit.sv
// Scoreboard bench for multicycle_controlunit: per-instruction expectations are
// queued as each instruction is issued and compared when it retires or traps.
module tb_multicycle_controlunit;

    localparam int WIDTH       = 32;
    localparam int MEM_TIMEOUT = 15;
    localparam int CNT_W       = 4;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] instr = '0;
    logic             imem_ready = 1'b0;
    logic             dmem_ready = 1'b0;
    logic             EQ = 1'b0;
    logic             IRWrite, ImemRead, MemRead, MemWrite, PCWrite, PCsrc, RegWrite, ALUsrc;
    logic [2:0]       ImmSrc, ALUctrl, state_o;
    logic [1:0]       ResultSrc, trap_code;
    logic             trap;
    logic [CNT_W-1:0] retired;

    multicycle_controlunit #(
        .WIDTH       (WIDTH),
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .EQ         (EQ),
        .IRWrite    (IRWrite),
        .ImemRead   (ImemRead),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .PCWrite    (PCWrite),
        .PCsrc      (PCsrc),
        .RegWrite   (RegWrite),
        .ALUsrc     (ALUsrc),
        .ImmSrc     (ImmSrc),
        .ALUctrl    (ALUctrl),
        .ResultSrc  (ResultSrc),
        .trap       (trap),
        .trap_code  (trap_code),
        .retired    (retired),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [CNT_W-1:0] model_retired = '0;

    typedef struct {
        int             cycles;
        logic           trapped;
        logic           timeout;
        logic           rw_any;
        logic [1:0]     rs_ret;
        logic           pcsrc_ret;
        logic           ex_alusrc;
        logic [2:0]     ex_imm;
        logic [2:0]     ex_alu;
        int             mrd;
        int             mwr;
        logic [15:0][2:0] st;
    } obs_t;

    typedef struct {
        string          name;
        logic [31:0]    ins;
        logic           eq;
        int             delay;
        int             cycles;
        logic           rw;
        logic [1:0]     rs;
        logic           pcsrc;
        logic           alusrc;
        logic [2:0]     imm;
        logic [2:0]     alu;
        int             mrd;
        int             mwr;
        logic [2:0]     last_st;
        logic [CNT_W-1:0] retired;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t mk(input string n, input logic [31:0] ins, input logic eq, input int delay,
                                input int cycles, input logic rw, input logic [1:0] rs, input logic pcsrc,
                                input logic alusrc, input logic [2:0] imm, input logic [2:0] alu,
                                input int mrd, input int mwr, input logic [2:0] last_st);
        exp_t e;
        e.name = n; e.ins = ins; e.eq = eq; e.delay = delay; e.cycles = cycles; e.rw = rw;
        e.rs = rs; e.pcsrc = pcsrc; e.alusrc = alusrc; e.imm = imm; e.alu = alu;
        e.mrd = mrd; e.mwr = mwr; e.last_st = last_st; e.retired = '0;
        return e;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    // Runs one instruction from the current negedge until it retires or traps.
    task automatic run_instr(input logic [31:0] ins, input logic eq, input int delay, output obs_t o);
        int   mem_cnt;
        logic done;
        mem_cnt = 0; done = 1'b0;
        o.cycles = 0; o.trapped = 1'b0; o.timeout = 1'b0; o.rw_any = 1'b0; o.rs_ret = 2'b00;
        o.pcsrc_ret = 1'b0; o.ex_alusrc = 1'b0; o.ex_imm = 3'b000; o.ex_alu = 3'b000;
        o.mrd = 0; o.mwr = 0; o.st = '0;
        instr = ins;
        for (int c = 0; c < 80; c++) begin
            logic [2:0] st;
            st = state_o;
            imem_ready = 1'b1;
            dmem_ready = (st == S_MEM) && (mem_cnt >= delay);
            EQ = eq;
            #1;
            if (c < 16) o.st[c] = st;
            if (st == S_TRAP) begin
                o.trapped = 1'b1;
                done = 1'b1;
            end else begin
                o.cycles = c + 1;
                if (RegWrite) o.rw_any = 1'b1;
                if (MemRead)  o.mrd++;
                if (MemWrite) o.mwr++;
                if (st == S_EXEC) begin
                    o.ex_alusrc = ALUsrc; o.ex_imm = ImmSrc; o.ex_alu = ALUctrl;
                end
                if (st == S_MEM) mem_cnt++;
                if (PCWrite) begin
                    o.pcsrc_ret = PCsrc; o.rs_ret = ResultSrc; done = 1'b1;
                end
            end
            @(negedge clk);
            if (done) break;
        end
        if (!done) o.timeout = 1'b1;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (state_o !== S_FETCH) begin errors++; $display("FAIL reset_state got %0d want %0d", state_o, S_FETCH); end
        checks++; if ({trap, trap_code} !== 3'b000) begin errors++; $display("FAIL reset_trap got %b%b want 000", trap, trap_code); end
        checks++; if (retired !== '0) begin errors++; $display("FAIL reset_retired got %0d want 0", retired); end
        checks++; if ({ImemRead, IRWrite, MemRead, MemWrite, PCWrite, RegWrite} !== 6'b100000) begin
            errors++; $display("FAIL reset_strobes got %b want 100000", {ImemRead, IRWrite, MemRead, MemWrite, PCWrite, RegWrite}); end
        checks++; if ({ALUsrc, ImmSrc, ALUctrl, ResultSrc} !== 9'b1_111_111_00) begin
            errors++; $display("FAIL reset_idle_ctrl got %b want 111111100", {ALUsrc, ImmSrc, ALUctrl, ResultSrc}); end
        // Abandon an ADDI in EXEC: no retirement may be counted.
        instr = 32'h00500093; imem_ready = 1'b1;
        repeat (2) @(negedge clk);
        imem_ready = 1'b0;
        checks++; if (state_o !== S_EXEC) begin errors++; $display("FAIL midreset_pre got %0d want %0d", state_o, S_EXEC); end
        do_reset();
        checks++; if ({state_o, retired} !== {S_FETCH, {CNT_W{1'b0}}}) begin
            errors++; $display("FAIL midreset_post state %0d retired %0d want %0d 0", state_o, retired, S_FETCH); end
        $display("test_reset done");
    endtask

    task automatic test_instr_mix();
        exp_t tbl[$];
        exp_t e;
        obs_t o;
        tbl.push_back(mk("addi",    32'h00500093, 1'b0, 0, 4, 1'b1, 2'b00, 1'b0, 1'b1, 3'b000, 3'b000, 0, 0, S_WB));
        tbl.push_back(mk("bne_ne",  32'h00209463, 1'b0, 0, 3, 1'b0, 2'b00, 1'b1, 1'b0, 3'b010, 3'b001, 0, 0, S_EXEC));
        tbl.push_back(mk("bne_eq",  32'h00209463, 1'b1, 0, 3, 1'b0, 2'b00, 1'b0, 1'b0, 3'b010, 3'b001, 0, 0, S_EXEC));
        tbl.push_back(mk("beq_eq",  32'h00208463, 1'b1, 0, 3, 1'b0, 2'b00, 1'b1, 1'b0, 3'b010, 3'b001, 0, 0, S_EXEC));
        tbl.push_back(mk("beq_ne",  32'h00208463, 1'b0, 0, 3, 1'b0, 2'b00, 1'b0, 1'b0, 3'b010, 3'b001, 0, 0, S_EXEC));
        tbl.push_back(mk("lw_wait3",32'h0000A103, 1'b0, 3, 8, 1'b1, 2'b01, 1'b0, 1'b1, 3'b000, 3'b000, 4, 0, S_WB));
        tbl.push_back(mk("lw",      32'h0000A103, 1'b0, 0, 5, 1'b1, 2'b01, 1'b0, 1'b1, 3'b000, 3'b000, 1, 0, S_WB));
        tbl.push_back(mk("sw",      32'h0020A023, 1'b0, 0, 4, 1'b0, 2'b00, 1'b0, 1'b1, 3'b001, 3'b000, 0, 1, S_MEM));
        tbl.push_back(mk("sw_wait2",32'h0020A023, 1'b1, 2, 6, 1'b0, 2'b00, 1'b0, 1'b1, 3'b001, 3'b000, 0, 3, S_MEM));
        tbl.push_back(mk("add",     32'h002081B3, 1'b0, 0, 4, 1'b1, 2'b00, 1'b0, 1'b0, 3'b111, 3'b000, 0, 0, S_WB));
        tbl.push_back(mk("sub",     32'h402081B3, 1'b1, 0, 4, 1'b1, 2'b00, 1'b0, 1'b0, 3'b111, 3'b001, 0, 0, S_WB));
        tbl.push_back(mk("lui",     32'h123452B7, 1'b0, 0, 4, 1'b1, 2'b10, 1'b0, 1'b1, 3'b011, 3'b111, 0, 0, S_WB));
        tbl.push_back(mk("addi_x0", 32'h00100013, 1'b0, 0, 4, 1'b0, 2'b00, 1'b0, 1'b1, 3'b000, 3'b000, 0, 0, S_WB));
        foreach (tbl[i]) begin
            e = tbl[i];
            model_retired = model_retired + 1'b1;
            e.retired = model_retired;
            sb.push_back(e);
            run_instr(e.ins, e.eq, e.delay, o);
            e = sb.pop_front();
            checks++; if ({o.timeout, o.trapped} !== 2'b00) begin errors++; $display("FAIL %s completion timeout=%0b trapped=%0b want 0 0", e.name, o.timeout, o.trapped); end
            checks++; if (o.cycles != e.cycles) begin errors++; $display("FAIL %s latency got %0d want %0d", e.name, o.cycles, e.cycles); end
            checks++; if ({o.st[0], o.st[1], o.st[2]} !== {S_FETCH, S_DECODE, S_EXEC}) begin
                errors++; $display("FAIL %s state_seq got %0d,%0d,%0d want 0,1,2", e.name, o.st[0], o.st[1], o.st[2]); end
            if (o.cycles >= 1 && o.cycles <= 16) begin
                checks++; if (o.st[o.cycles-1] !== e.last_st) begin errors++; $display("FAIL %s retire_state got %0d want %0d", e.name, o.st[o.cycles-1], e.last_st); end
            end
            checks++; if (o.rw_any !== e.rw) begin errors++; $display("FAIL %s RegWrite got %0b want %0b", e.name, o.rw_any, e.rw); end
            checks++; if (o.rs_ret !== e.rs) begin errors++; $display("FAIL %s ResultSrc got %b want %b", e.name, o.rs_ret, e.rs); end
            checks++; if (o.pcsrc_ret !== e.pcsrc) begin errors++; $display("FAIL %s PCsrc got %0b want %0b", e.name, o.pcsrc_ret, e.pcsrc); end
            checks++; if ({o.ex_alusrc, o.ex_imm, o.ex_alu} !== {e.alusrc, e.imm, e.alu}) begin
                errors++; $display("FAIL %s exec_ctrl got %b/%b/%b want %b/%b/%b", e.name, o.ex_alusrc, o.ex_imm, o.ex_alu, e.alusrc, e.imm, e.alu); end
            checks++; if (o.mrd != e.mrd || o.mwr != e.mwr) begin
                errors++; $display("FAIL %s mem_cycles got rd %0d wr %0d want rd %0d wr %0d", e.name, o.mrd, o.mwr, e.mrd, e.mwr); end
            checks++; if (retired !== e.retired) begin errors++; $display("FAIL %s retired got %0d want %0d", e.name, retired, e.retired); end
            $display("instr %-8s 0x%08h cycles %0d retired %0d", e.name, e.ins, o.cycles, retired);
        end
    endtask

    task automatic test_illegal();
        obs_t o;
        logic [31:0] bad[2];
        bad[0] = 32'h0000007F;
        bad[1] = 32'h00101093;
        foreach (bad[i]) begin
            run_instr(bad[i], 1'b0, 0, o);
            checks++; if (!(o.trapped === 1'b1 && o.cycles == 2)) begin errors++; $display("FAIL illegal_trap 0x%08h trapped %0b after %0d want 1 after 2", bad[i], o.trapped, o.cycles); end
            imem_ready = 1'b1; dmem_ready = 1'b1; EQ = 1'b1;
            repeat (3) @(negedge clk);
            #1;
            checks++; if ({state_o, trap, trap_code} !== {S_TRAP, 1'b1, 2'b01}) begin
                errors++; $display("FAIL illegal_sticky state %0d trap %0b code %b want %0d 1 01", state_o, trap, trap_code, S_TRAP); end
            checks++; if ({ImemRead, IRWrite, MemRead, MemWrite, PCWrite, RegWrite} !== 6'b000000) begin
                errors++; $display("FAIL illegal_strobes got %b want 000000", {ImemRead, IRWrite, MemRead, MemWrite, PCWrite, RegWrite}); end
            checks++; if (retired !== model_retired) begin errors++; $display("FAIL illegal_retired got %0d want %0d", retired, model_retired); end
            do_reset();
            model_retired = '0;
            checks++; if ({state_o, trap, trap_code, retired} !== {S_FETCH, 1'b0, 2'b00, {CNT_W{1'b0}}}) begin
                errors++; $display("FAIL trap_exit state %0d trap %0b code %b retired %0d want 0 0 00 0", state_o, trap, trap_code, retired); end
            $display("illegal 0x%08h trapped, reset clears", bad[i]);
        end
    endtask

    task automatic test_imem_timeout();
        do_reset();
        instr = 32'h00500093;
        repeat (MEM_TIMEOUT - 1) @(negedge clk);
        #1;
        checks++; if ({state_o, ImemRead} !== {S_FETCH, 1'b1}) begin errors++; $display("FAIL imem_wait14 state %0d ImemRead %0b want 0 1", state_o, ImemRead); end
        @(negedge clk);
        #1;
        checks++; if ({state_o, trap, trap_code} !== {S_TRAP, 1'b1, 2'b10}) begin
            errors++; $display("FAIL imem_timeout state %0d trap %0b code %b want 5 1 10", state_o, trap, trap_code); end
        do_reset();
        repeat (MEM_TIMEOUT - 1) @(negedge clk);
        imem_ready = 1'b1;
        #1;
        checks++; if (IRWrite !== 1'b1) begin errors++; $display("FAIL imem_late_irwrite got %0b want 1", IRWrite); end
        @(negedge clk);
        imem_ready = 1'b0;
        #1;
        checks++; if ({state_o, trap} !== {S_DECODE, 1'b0}) begin errors++; $display("FAIL imem_late_ready state %0d trap %0b want 1 0", state_o, trap); end
        do_reset();
        model_retired = '0;
        $display("imem timeout boundary exercised");
    endtask

    task automatic test_dmem_timeout();
        obs_t o;
        do_reset();
        model_retired = '0;
        run_instr(32'h0000A103, 1'b0, 1000, o);
        checks++; if (!(o.trapped === 1'b1 && o.cycles == 3 + MEM_TIMEOUT)) begin
            errors++; $display("FAIL dmem_timeout trapped %0b after %0d want 1 after %0d", o.trapped, o.cycles, 3 + MEM_TIMEOUT); end
        checks++; if (o.mrd != MEM_TIMEOUT) begin errors++; $display("FAIL dmem_memread_cycles got %0d want %0d", o.mrd, MEM_TIMEOUT); end
        checks++; if ({trap, trap_code, retired} !== {1'b1, 2'b11, {CNT_W{1'b0}}}) begin
            errors++; $display("FAIL dmem_trap trap %0b code %b retired %0d want 1 11 0", trap, trap_code, retired); end
        do_reset();
        $display("dmem timeout trapped after %0d cycles", o.cycles);
    endtask

    task automatic test_back_to_back_wrap();
        exp_t e;
        obs_t o;
        do_reset();
        model_retired = '0;
        for (int i = 0; i < (1 << CNT_W); i++) begin
            e = mk("addi_x0", 32'h00100013, 1'b0, 0, 4, 1'b0, 2'b00, 1'b0, 1'b1, 3'b000, 3'b000, 0, 0, S_WB);
            model_retired = model_retired + 1'b1;
            e.retired = model_retired;
            sb.push_back(e);
            run_instr(e.ins, e.eq, e.delay, o);
            e = sb.pop_front();
            checks++; if ({o.timeout, o.trapped, o.rw_any} !== 3'b000 || o.cycles != e.cycles) begin
                errors++; $display("FAIL wrap_%0d run timeout %0b trapped %0b RegWrite %0b cycles %0d want 0 0 0 %0d", i, o.timeout, o.trapped, o.rw_any, o.cycles, e.cycles); end
            checks++; if (retired !== e.retired) begin errors++; $display("FAIL wrap_%0d retired got %0d want %0d", i, retired, e.retired); end
            $display("wrap instr %0d retired %0d", i, retired);
        end
    endtask

    initial begin
        test_reset();
        test_instr_mix();
        test_illegal();
        test_imem_timeout();
        test_dmem_timeout();
        test_back_to_back_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
